// File: rtl/spi_timer_service_pkg.sv
// Shared definitions for the timer service block: timer register map,
// control bit positions and the service FSM state encoding.
package spi_timer_service_pkg;

    localparam logic [2:0] TMR_STATUS  = 3'd0;
    localparam logic [2:0] TMR_CONTROL = 3'd1;
    localparam logic [2:0] TMR_PERIODL = 3'd2;
    localparam logic [2:0] TMR_PERIODH = 3'd3;
    localparam logic [2:0] TMR_SNAPL   = 3'd4;
    localparam logic [2:0] TMR_SNAPH   = 3'd5;

    localparam int unsigned CTRL_ITO_BIT   = 0;
    localparam int unsigned CTRL_CONT_BIT  = 1;
    localparam int unsigned CTRL_START_BIT = 2;
    localparam int unsigned CTRL_STOP_BIT  = 3;

    typedef enum logic [3:0] {
        ST_INIT_PL,
        ST_INIT_PH,
        ST_INIT_CTL,
        ST_IDLE,
        ST_CLR,
        ST_SNAP,
        ST_RD_L,
        ST_RD_H,
        ST_RD_DONE,
        ST_POST
    } state_t;

endpackage

// File: rtl/spi_timer_service_tick_slot.sv
// spi_tick_slot: one-entry valid/ready tick register with a sequence counter
// and a sticky overrun flag for ticks offered while the slot is still full.
module spi_tick_slot (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic [31:0] i_snap,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [15:0] o_count,
    output logic [31:0] o_snap,
    output logic        o_overrun
);

    logic        r_valid;
    logic [15:0] r_count;
    logic [31:0] r_snap;
    logic        r_overrun;
    logic        w_take;

    // A new tick may replace the held one in the same cycle it is consumed.
    assign w_take = i_load & (~r_valid | i_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_count   <= '0;
            r_snap    <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_take) begin
                r_valid <= 1'b1;
                r_snap  <= i_snap;
                r_count <= r_count + 16'd1;
            end else if (r_valid & i_ready) begin
                r_valid <= 1'b0;
            end
            if (i_load & ~w_take) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign o_valid   = r_valid;
    assign o_count   = r_count;
    assign o_snap    = r_snap;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/spi_timer_service.sv
// Programs a memory-mapped interval timer, services its timeout interrupt by
// snapshotting the counter, and hands each event to a valid/ready consumer.
module spi_timer_service
    import spi_timer_service_pkg::*;
#(
    parameter logic [31:0] PERIOD_INIT = 32'd49,
    parameter logic [3:0]  CTRL_INIT   = 4'h7
) (
    input  logic        clk,
    input  logic        reset,
    output logic [2:0]  tmr_address,
    output logic        tmr_chipselect,
    output logic        tmr_write_n,
    output logic [15:0] tmr_writedata,
    input  logic [15:0] tmr_readdata,
    input  logic        tmr_irq,
    input  logic [31:0] cfg_period,
    input  logic        cfg_load,
    output logic        tick_valid,
    input  logic        tick_ready,
    output logic [15:0] tick_count,
    output logic [31:0] tick_snap,
    output logic        overrun
);

    state_t      r_state, w_next;
    logic [31:0] r_period, w_period;
    logic [15:0] r_snap_lo, r_snap_hi;
    logic [2:0]  r_addr, w_addr;
    logic        r_cs, w_cs;
    logic        r_wn, w_wn;
    logic [15:0] r_wdata, w_wdata;
    logic        w_load_tick;

    always_comb begin
        w_next      = r_state;
        w_period    = r_period;
        w_load_tick = 1'b0;
        unique case (r_state)
            // Bus is registered from the state being entered; the extra INIT_PL
            // cycle after reset exists only to issue its (not yet driven) write.
            ST_INIT_PL:  w_next = r_cs ? ST_INIT_PH : ST_INIT_PL;
            ST_INIT_PH:  w_next = ST_INIT_CTL;
            ST_INIT_CTL: w_next = ST_IDLE;
            ST_IDLE: begin
                if (cfg_load) begin
                    w_period = cfg_period;
                    w_next   = ST_INIT_PL;
                end else if (tmr_irq) begin
                    w_next = ST_CLR;
                end
            end
            ST_CLR:     w_next = ST_SNAP;
            ST_SNAP:    w_next = ST_RD_L;
            ST_RD_L:    w_next = ST_RD_H;
            ST_RD_H:    w_next = ST_RD_DONE;
            ST_RD_DONE: w_next = ST_POST;
            ST_POST: begin
                w_load_tick = 1'b1;
                w_next      = ST_IDLE;
            end
            default:    w_next = ST_INIT_PL;
        endcase
    end

    always_comb begin
        w_cs    = 1'b0;
        w_wn    = 1'b1;
        w_addr  = '0;
        w_wdata = '0;
        unique case (w_next)
            ST_INIT_PL:  begin w_cs = 1'b1; w_wn = 1'b0; w_addr = TMR_PERIODL; w_wdata = w_period[15:0]; end
            ST_INIT_PH:  begin w_cs = 1'b1; w_wn = 1'b0; w_addr = TMR_PERIODH; w_wdata = w_period[31:16]; end
            ST_INIT_CTL: begin w_cs = 1'b1; w_wn = 1'b0; w_addr = TMR_CONTROL; w_wdata = {12'h000, CTRL_INIT}; end
            ST_CLR:      begin w_cs = 1'b1; w_wn = 1'b0; w_addr = TMR_STATUS; end
            ST_SNAP:     begin w_cs = 1'b1; w_wn = 1'b0; w_addr = TMR_SNAPL; end
            ST_RD_L:     begin w_cs = 1'b1; w_addr = TMR_SNAPL; end
            ST_RD_H:     begin w_cs = 1'b1; w_addr = TMR_SNAPH; end
            default:     ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_INIT_PL;
            r_period  <= PERIOD_INIT;
            r_snap_lo <= '0;
            r_snap_hi <= '0;
            r_cs      <= 1'b0;
            r_wn      <= 1'b1;
            r_addr    <= '0;
            r_wdata   <= '0;
        end else begin
            r_state  <= w_next;
            r_period <= w_period;
            r_cs     <= w_cs;
            r_wn     <= w_wn;
            r_addr   <= w_addr;
            r_wdata  <= w_wdata;
            // Slave readdata trails the address by one cycle.
            if (r_state == ST_RD_H)    r_snap_lo <= tmr_readdata;
            if (r_state == ST_RD_DONE) r_snap_hi <= tmr_readdata;
        end
    end

    assign tmr_address    = r_addr;
    assign tmr_chipselect = r_cs;
    assign tmr_write_n    = r_wn;
    assign tmr_writedata  = r_wdata;

    spi_tick_slot u_slot (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_load_tick),
        .i_snap    ({r_snap_hi, r_snap_lo}),
        .i_ready   (tick_ready),
        .o_valid   (tick_valid),
        .o_count   (tick_count),
        .o_snap    (tick_snap),
        .o_overrun (overrun)
    );

endmodule

// File: tb/tb_spi_timer_service.sv
// Directed bench for spi_timer_service with a minimal timer slave model
// whose readdata follows the read address by one cycle.
module tb_spi_timer_service;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic [15:0] tmr_readdata = '0;
    logic        tmr_irq;
    logic [31:0] cfg_period;
    logic        cfg_load;
    logic        tick_valid;
    logic        tick_ready;
    logic [15:0] tick_count;
    logic [31:0] tick_snap;
    logic        overrun;

    logic [31:0] m_snap = '0;
    int          tests = 0;
    int          fails = 0;

    spi_timer_service #(.PERIOD_INIT(32'd49), .CTRL_INIT(4'h7)) dut (
        .clk            (clk),
        .reset          (reset),
        .tmr_address    (tmr_address),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_writedata  (tmr_writedata),
        .tmr_readdata   (tmr_readdata),
        .tmr_irq        (tmr_irq),
        .cfg_period     (cfg_period),
        .cfg_load       (cfg_load),
        .tick_valid     (tick_valid),
        .tick_ready     (tick_ready),
        .tick_count     (tick_count),
        .tick_snap      (tick_snap),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tmr_chipselect && tmr_write_n && tmr_address == 3'd4)
            tmr_readdata <= m_snap[15:0];
        else if (tmr_chipselect && tmr_write_n && tmr_address == 3'd5)
            tmr_readdata <= m_snap[31:16];
        else
            tmr_readdata <= '0;
    end

    function automatic logic [31:0] bus_now();
        return {11'b0, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata};
    endfunction

    function automatic logic [31:0] wr(input logic [2:0] a, input logic [15:0] d);
        return {11'b0, 1'b1, 1'b0, a, d};
    endfunction

    function automatic logic [31:0] rd(input logic [2:0] a);
        return {11'b0, 1'b1, 1'b1, a, 16'h0000};
    endfunction

    localparam logic [31:0] BUS_IDLE = {11'b0, 1'b0, 1'b1, 3'd0, 16'h0000};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full service from IDLE: irq seen at edge n, tick loaded at edge n+6.
    task automatic service(input logic [31:0] snap, input logic ready_at_post);
        m_snap  = snap;
        tmr_irq = 1'b1;
        step();
        tmr_irq = 1'b0;
        repeat (5) step();
        tick_ready = ready_at_post;
        step();
    endtask

    initial begin
        reset      = 1'b1;
        tmr_irq    = 1'b0;
        cfg_period = '0;
        cfg_load   = 1'b0;
        tick_ready = 1'b0;
        repeat (3) step();
        chk("reset_bus", bus_now(), BUS_IDLE);
        chk("reset_tick", {tick_valid, overrun, tick_count}, 32'h0);
        chk("reset_snap", tick_snap, 32'h0);

        reset = 1'b0;
        step();
        chk("init_pl", bus_now(), wr(3'd2, 16'h0031));
        step();
        chk("init_ph", bus_now(), wr(3'd3, 16'h0000));
        step();
        chk("init_ctl", bus_now(), wr(3'd1, 16'h0007));
        step();
        chk("init_idle", bus_now(), BUS_IDLE);

        m_snap  = 32'h0000_0017;
        tmr_irq = 1'b1;
        step();
        chk("svc_clr", bus_now(), wr(3'd0, 16'h0000));
        tmr_irq = 1'b0;
        step();
        chk("svc_snap", bus_now(), wr(3'd4, 16'h0000));
        step();
        chk("svc_rdl", bus_now(), rd(3'd4));
        step();
        chk("svc_rdh", bus_now(), rd(3'd5));
        step();
        chk("svc_n4_valid", {31'b0, tick_valid}, 32'h0);
        step();
        chk("svc_n5_valid", {31'b0, tick_valid}, 32'h0);
        step();
        chk("svc_n6_valid", {31'b0, tick_valid}, 32'h1);
        chk("svc_snapv", tick_snap, 32'h0000_0017);
        chk("svc_count", {16'h0, tick_count}, 32'h1);
        chk("svc_no_ovr", {31'b0, overrun}, 32'h0);

        service(32'h0000_0042, 1'b0);
        tick_ready = 1'b0;
        chk("ovr_flag", {31'b0, overrun}, 32'h1);
        chk("ovr_held_snap", tick_snap, 32'h0000_0017);
        chk("ovr_held_cnt", {15'h0, tick_valid, tick_count}, 32'h0001_0001);

        tick_ready = 1'b1;
        step();
        tick_ready = 1'b0;
        chk("consume", {31'b0, tick_valid}, 32'h0);

        service(32'h1234_5678, 1'b0);
        tick_ready = 1'b0;
        chk("hi_snap", tick_snap, 32'h1234_5678);
        chk("hi_count", {15'h0, tick_valid, tick_count}, 32'h0001_0002);

        service(32'hABCD_0001, 1'b1);
        tick_ready = 1'b0;
        chk("reload_snap", tick_snap, 32'hABCD_0001);
        chk("reload_count", {15'h0, tick_valid, tick_count}, 32'h0001_0003);

        tick_ready = 1'b1;
        step();
        tick_ready = 1'b0;

        m_snap     = 32'h0000_0055;
        cfg_period = 32'h0001_86A0;
        cfg_load   = 1'b1;
        tmr_irq    = 1'b1;
        step();
        cfg_load   = 1'b0;
        chk("cfg_pl", bus_now(), wr(3'd2, 16'h86A0));
        step();
        chk("cfg_ph", bus_now(), wr(3'd3, 16'h0001));
        step();
        chk("cfg_ctl", bus_now(), wr(3'd1, 16'h0007));
        step();
        chk("cfg_idle", bus_now(), BUS_IDLE);
        step();
        chk("cfg_pending_clr", bus_now(), wr(3'd0, 16'h0000));
        tmr_irq    = 1'b0;
        cfg_period = 32'hDEAD_BEEF;
        cfg_load   = 1'b1;
        step();
        cfg_load   = 1'b0;
        chk("load_ignored", bus_now(), wr(3'd4, 16'h0000));
        repeat (5) step();
        chk("cfg_svc_snap", tick_snap, 32'h0000_0055);
        chk("cfg_svc_count", {15'h0, tick_valid, tick_count}, 32'h0001_0004);
        step();
        chk("post_idle", bus_now(), BUS_IDLE);

        tick_ready = 1'b1;
        step();
        tick_ready = 1'b0;
        force dut.u_slot.r_count = 16'hFFFF;
        step();
        release dut.u_slot.r_count;
        step();
        chk("preset", {16'h0, tick_count}, 32'h0000_FFFF);
        service(32'h0000_0099, 1'b0);
        tick_ready = 1'b0;
        chk("wrap", {15'h0, tick_valid, tick_count}, 32'h0001_0000);

        tmr_irq = 1'b1;
        step();
        tmr_irq = 1'b0;
        repeat (3) step();
        chk("rst_at_rdh", bus_now(), rd(3'd5));
        reset = 1'b1;
        step();
        chk("rst_bus", bus_now(), BUS_IDLE);
        chk("rst_tick", {tick_valid, overrun, 14'h0, tick_count}, 32'h0);
        chk("rst_snap", tick_snap, 32'h0);
        reset = 1'b0;
        step();
        chk("reinit_pl", bus_now(), wr(3'd2, 16'h0031));
        step();
        chk("reinit_ph", bus_now(), wr(3'd3, 16'h0000));
        step();
        chk("reinit_ctl", bus_now(), wr(3'd1, 16'h0007));
        step();
        chk("reinit_idle", bus_now(), BUS_IDLE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_timer_service.md
SPI_TIMER_SERVICE -- requirements
Module: spi_timer_service

Interface
REQ-001 SHALL have parameter PERIOD_INIT, default 32'd49, meaning timer period written during the init sequence.
REQ-002 SHALL have parameter CTRL_INIT, default 4'h7, meaning control word written during init (START | CONT | ITO).
REQ-003 SHALL have port clk  in  1  sole clock; all logic is on the rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port tmr_address  out  3  timer slave address.
REQ-006 SHALL have port tmr_chipselect  out  1  timer slave select.
REQ-007 SHALL have port tmr_write_n  out  1  active-low write strobe.
REQ-008 SHALL have port tmr_writedata  out  16  write data.
REQ-009 SHALL have port tmr_readdata  in  16  timer read data, registered by the slave one cycle after the address.
REQ-010 SHALL have port tmr_irq  in  1  timer timeout interrupt, level-sensitive.
REQ-011 SHALL have port cfg_period  in  32  new timer period.
REQ-012 SHALL have port cfg_load  in  1  one-cycle request to reprogram the period and restart the timer.
REQ-013 SHALL have port tick_valid  out  1  tick event available.
REQ-014 SHALL have port tick_ready  in  1  consumer accepts the tick.
REQ-015 SHALL have port tick_count  out  16  event sequence number.
REQ-016 SHALL have port tick_snap  out  32  counter snapshot captured at service time.
REQ-017 SHALL have port overrun  out  1  sticky flag: at least one tick dropped; cleared only by reset.

Function
REQ-018 All tmr_* outputs SHALL be registered; an idle bus SHALL have chipselect=0, write_n=1, address=0, writedata=0.
REQ-019 Each FSM state SHALL last exactly one cycle except IDLE.
REQ-020 The FSM SHALL follow INIT_PL -> INIT_PH -> INIT_CTL -> IDLE, writing addr2=period[15:0], addr3=period[31:16], addr1=CTRL_INIT.
REQ-021 In IDLE, cfg_load SHALL latch cfg_period and re-enter INIT_PL.
REQ-022 In IDLE without cfg_load, tmr_irq=1 SHALL enter CLR.
REQ-023 cfg_load SHALL win when it and tmr_irq are both asserted in IDLE.
REQ-024 cfg_load SHALL be ignored outside IDLE (no queuing).
REQ-025 The service path SHALL be CLR (write addr0, data 0) -> SNAP (write addr4, data 0) -> RD_L (read addr4) -> RD_H (read addr5; sample readdata as snap[15:0]) -> RD_DONE (sample readdata as snap[31:16]) -> POST -> IDLE.
REQ-026 In POST, if tick_valid=0 or tick_ready=1 in that cycle, the FSM SHALL load tick_snap, increment tick_count (mod 2^16, wraps 0xFFFF->0x0000), and assert tick_valid.
REQ-027 In POST, otherwise the FSM SHALL set overrun and leave the held tick unchanged.
REQ-028 tick_valid SHALL clear on tick_valid & tick_ready unless reloaded in the same cycle.
REQ-029 tick payload SHALL be stable while tick_valid=1 and tick_ready=0.
REQ-030 End-to-end latency SHALL be irq seen in IDLE at cycle n -> tick_valid=1 at cycle n+6.
REQ-031 The FSM SHALL NOT re-enter CLR from POST; IDLE samples irq fresh, which is deasserted by then via the CLR write.

Reset
REQ-032 On reset the FSM SHALL enter INIT_PL with the period register set to PERIOD_INIT.
REQ-033 On reset tick_valid, tick_count, tick_snap and overrun SHALL be 0, and the bus SHALL be idle.
REQ-034 Reset SHALL abort any in-progress sequence; the init sequence restarts on the first cycle after reset deasserts.

Structure
REQ-035 A shared package SHALL hold the timer register address constants (STATUS=0, CONTROL=1, PERIODL=2, PERIODH=3, SNAPL=4, SNAPH=5), the control bit positions and the FSM state enum.
REQ-036 The block SHALL contain one sub-module, spi_tick_slot: a one-entry valid/ready output register with overrun detection.

Verification
REQ-037 The bench SHALL check: reset release -> writes 0x0031@2, 0x0000@3, 0x0007@1 on three consecutive cycles, then IDLE.
REQ-038 The bench SHALL check: timer model raises irq with snapshot 0x0000_0017 -> write 0@0, write@4, reads 4/5 -> tick_valid at n+6 with tick_snap=0x17, tick_count=1.
REQ-039 The bench SHALL check: tick_ready held 0 across two irqs -> first tick payload held, overrun=1, tick_count stays 1.
REQ-040 The bench SHALL check: cfg_load with 0x0001_86A0 and irq in the same IDLE cycle -> writes 0x86A0@2, 0x0001@3, 0x0007@1, then the pending irq is serviced.
REQ-041 The bench SHALL check: tick_count preset to 0xFFFF, one event -> tick_count=0x0000.
REQ-042 The bench SHALL check: reset asserted during RD_H -> bus idle, outputs zero, init sequence reissued.
